// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch sequencer with redirect/trap flush
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        pc_en_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        trap_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    input  logic        if_ready_i
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t      state;
    logic        flush;
    logic [31:0] pc_plus4;

    // The PC register only exists after the IDLE cycle, so flushes are ignored there.
    assign flush       = (redirect_i || trap_i) && (state != IDLE);
    assign pc_plus4    = pc_i + 32'd4;
    assign imem_addr_o = pc_i;
    assign if_pc_o     = pc_i;
    assign if_valid_o  = (state == HOLD);

    always_comb begin
        imem_req_o = (state == REQ) && !flush;
        pc_en_o    = flush || ((state == HOLD) && if_ready_i);
        next_pc_o  = pc_plus4;
        if (rst)
            next_pc_o = RESET_PC;
        else if (flush)
            next_pc_o = trap_i ? TRAP_VEC : redirect_pc_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            if_instr_o <= 32'd0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (!flush && imem_gnt_i)
                        state <= WAIT;
                end
                WAIT: begin
                    if (flush)
                        state <= imem_rvalid_i ? REQ : DROP;
                    else if (imem_rvalid_i) begin
                        if_instr_o <= imem_rdata_i;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || if_ready_i)
                        state <= REQ;
                end
                // The stale response must still be absorbed before a new request can go out.
                DROP: begin
                    if (imem_rvalid_i)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with transaction-level model
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        trap = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_q),
        .next_pc_o    (next_pc),
        .pc_en_o      (pc_en),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .trap_i       (trap),
        .if_valid_o   (if_valid),
        .if_instr_o   (if_instr),
        .if_pc_o      (if_pc),
        .if_ready_i   (if_ready)
    );

    // PC register owned by the environment
    always @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= 32'd0;
        else if (pc_en)
            pc_q <= next_pc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Transaction model: started / outstanding request / stale flag / instruction buffer
    bit          m_started, m_out, m_stale, m_buf_v;
    logic [31:0] m_buf_d;

    always @(negedge clk) begin
        bit          fl, e_req, e_en;
        logic [31:0] e_next;
        if (rst) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
            chk("rst_valid", {31'd0, if_valid}, 32'd0);
            chk("rst_instr", if_instr, 32'd0);
            chk("rst_next_pc", next_pc, 32'd0);
            m_started = 0; m_out = 0; m_stale = 0; m_buf_v = 0; m_buf_d = 32'd0;
        end else begin
            fl     = m_started && (redirect || trap);
            e_req  = m_started && !m_out && !m_buf_v && !fl;
            e_en   = fl || (m_buf_v && if_ready);
            e_next = fl ? (trap ? 32'h100 : redirect_pc) : pc_q + 32'd4;
            chk("m_req", {31'd0, imem_req}, {31'd0, e_req});
            chk("m_pc_en", {31'd0, pc_en}, {31'd0, e_en});
            chk("m_next_pc", next_pc, e_next);
            chk("m_valid", {31'd0, if_valid}, {31'd0, m_buf_v});
            chk("m_instr", if_instr, m_buf_d);
            chk("m_if_pc", if_pc, pc_q);
            if (e_req)
                chk("m_addr", imem_addr, pc_q);
            if (!m_started)
                m_started = 1;
            else begin
                if (m_buf_v && (fl || if_ready))
                    m_buf_v = 0;
                if (m_out && rvalid) begin
                    m_out = 0;
                    if (!(m_stale || fl)) begin
                        m_buf_v = 1;
                        m_buf_d = rdata;
                    end
                end else if (m_out && fl)
                    m_stale = 1;
                if (e_req && gnt) begin
                    m_out   = 1;
                    m_stale = 0;
                end
            end
        end
    end

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic red, input logic [31:0] rpc, input logic tr,
                         input logic rdy);
        gnt = g; rvalid = rv; rdata = rd;
        redirect = red; redirect_pc = rpc; trap = tr; if_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Basic fetch, immediate grant, response next cycle
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("idle_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("req0", {31'd0, imem_req}, 32'd1);
        chk("addr0", imem_addr, 32'd0);
        tick();
        drive(0, 1, 32'h13, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("valid0", {31'd0, if_valid}, 32'd1);
        chk("instr0", if_instr, 32'h13);
        chk("if_pc0", if_pc, 32'd0);
        chk("pc_en0", {31'd0, pc_en}, 32'd1);
        chk("next_pc0", next_pc, 32'd4);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("addr4", imem_addr, 32'd4);
        chk("req4", {31'd0, imem_req}, 32'd1);
        tick();

        // Backpressure in HOLD
        drive(0, 1, 32'h0050_0093, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("bp_instr", if_instr, 32'h0050_0093);
            chk("bp_pc", if_pc, 32'd4);
            chk("bp_pc_en", {31'd0, pc_en}, 32'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("bp_next_pc", next_pc, 32'd8);
        tick();

        // Redirect in WAIT, stale response later
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 32'h200, 0, 0);
        chk("wr_pc_en", {31'd0, pc_en}, 32'd1);
        chk("wr_next_pc", next_pc, 32'h200);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("drop_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(0, 1, 32'hDEAD, 0, 0, 0, 1);
        chk("drop_valid", {31'd0, if_valid}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("drop_valid2", {31'd0, if_valid}, 32'd0);
        chk("addr200", imem_addr, 32'h200);
        tick();
        drive(0, 1, 32'h13, 0, 0, 0, 0);
        tick();

        // Trap + redirect in HOLD with coincident if_ready
        drive(0, 0, 0, 1, 32'h300, 1, 1);
        chk("trap_next_pc", next_pc, 32'h100);
        chk("trap_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("trap_valid", {31'd0, if_valid}, 32'd0);
        chk("addr100", imem_addr, 32'h100);
        tick();

        // Redirect in REQ without grant
        drive(0, 0, 0, 1, 32'h400, 0, 0);
        chk("rreq_masked", {31'd0, imem_req}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("addr400", imem_addr, 32'h400);
        tick();

        // Redirect in WAIT coincident with rvalid
        drive(0, 1, 32'hBAD, 1, 32'h500, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("addr500", imem_addr, 32'h500);
        tick();

        // Async reset mid-WAIT
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_idle_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_addr0", imem_addr, 32'd0);
        tick();
        drive(0, 1, 32'h13, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();

        // PC+4 wraps at the top of the address space
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 32'h13, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("wrap_next_pc", next_pc, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that owns the program-counter register's next_pc/pc_en inputs and the instruction-memory request channel. Issues one fetch at a time from the current PC and buffers the returned instruction toward decode with a valid/ready handshake. Applies branch/jump redirects and trap vectoring, discarding any in-flight response that became stale. Sits between the PC register, instruction memory and the IF/ID boundary.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; equals the PC register's reset value.
TRAP_VEC, 32'h0000_0100, target loaded on trap_i.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pc_i  in  32  current PC from the PC register
next_pc_o  out  32  next PC to the PC register
pc_en_o  out  1  PC register load enable
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (= pc_i)
imem_gnt_i  in  1  request accepted (meaningful only while imem_req_o=1)
imem_rvalid_i  in  1  response valid
imem_rdata_i  in  32  response instruction
redirect_i  in  1  branch/jump taken, from execute
redirect_pc_i  in  32  redirect target
trap_i  in  1  trap request
if_valid_o  out  1  instruction valid to decode
if_instr_o  out  32  buffered instruction
if_pc_o  out  32  PC of if_instr_o (= pc_i)
if_ready_i  in  1  decode accepts

Behaviour:
- Reset is asynchronous, active-high, on clk/rst. While rst: state IDLE, imem_req_o=0, pc_en_o=0, if_valid_o=0, if_instr_o=0, next_pc_o=RESET_PC.
- States: IDLE, REQ, WAIT, HOLD, DROP. At most one outstanding request.
- IDLE: single cycle after reset release, then REQ. No request is issued.
- REQ: imem_req_o=1 and imem_addr_o=pc_i, held stable until gnt. On gnt: go to WAIT.
- WAIT: on imem_rvalid_i, capture imem_rdata_i into the buffer and go to HOLD.
- HOLD: if_valid_o=1. On if_ready_i: pc_en_o=1 and next_pc_o=pc_i+4 (combinational, same cycle; wraps modulo 2^32), then go to REQ.
- Minimum timing, gnt in cycle 0 and rvalid in cycle 1: if_valid_o is high in cycle 2, and the next request is issued in cycle 3 at PC+4.
- When not loading, pc_en_o=0 and next_pc_o=pc_i+4.
- Redirect/trap, accepted in any state except IDLE:
  - pc_en_o=1 in the same cycle.
  - next_pc_o=TRAP_VEC if trap_i, else redirect_pc_i. Trap has priority over redirect.
  - imem_req_o is masked to 0 in that cycle, so no gnt can occur.
- Next state on redirect/trap, by current state:
  - REQ: stays REQ; the request is reissued next cycle at the new PC.
  - WAIT with imem_rvalid_i in the same cycle: response discarded, go to REQ.
  - WAIT without rvalid: go to DROP.
  - HOLD: if_valid_o drops next cycle, the buffer is discarded, go to REQ. A coincident if_ready_i is ignored; no pc_i+4 load occurs.
  - DROP: PC is updated, stay in DROP.
- DROP: no request, if_valid_o=0. On imem_rvalid_i, discard the response and go to REQ.
- Backpressure: in HOLD with if_ready_i=0, if_instr_o, if_pc_o and pc_i stay stable indefinitely.
- rvalid outside WAIT/DROP is a protocol violation; it is ignored.
- Reset mid-operation: immediate return to reset values. Any outstanding response is the memory's responsibility, since the memory is reset by the same rst.

Test Plan:
- Release reset, memory grants immediately and returns 32'h0000_0013 one cycle later -> no request in the IDLE cycle; req at addr 0; if_valid with instr 0x13 and if_pc 0; on if_ready, pc_en=1 and next_pc=4; next req at addr 4.
- Hold if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc stay constant and pc_en=0 throughout; accept on cycle 6 -> next_pc=pc+4.
- Assert redirect_i with target 0x200 in WAIT, rvalid 2 cycles later carrying 0xDEAD -> pc_en=1 and next_pc=0x200; state DROP; 0xDEAD never reaches if_valid; next req at addr 0x200.
- Assert trap_i and redirect_i (target 0x300) together in HOLD, with if_ready=1 -> next_pc=0x100; if_valid low next cycle; next req at addr 0x100.
- Assert redirect in REQ while the memory withholds gnt -> imem_req_o=0 that cycle; req reissued at the new PC the next cycle.
- Assert rst asynchronously mid-WAIT -> imem_req_o, pc_en_o and if_valid_o go low immediately; after release, fetch restarts at RESET_PC via IDLE.
